// File: rtl/dmem_unit_pkg.sv
// Shared definitions for the Y86 data-memory unit: data width, FSM encoding
// and the latched request bundle.
package dmem_unit_pkg;

    localparam int DATA_WID = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_WID-1:0] wdata;
        logic                read;
        logic                write;
    } mem_req_t;

endpackage

// File: rtl/dmem_byte_ram.sv
// Byte-wide RAM: one synchronous write port, one asynchronous read port.
module dmem_byte_ram #(
    parameter int MEM_BYTES = 1024,
    localparam int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_unit.sv
// Y86 memory-stage data unit: one 8-byte little-endian access per request,
// moved one byte per cycle against an internal byte RAM.
module dmem_unit
    import dmem_unit_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [DATA_WID-1:0] addr,
    input  logic [DATA_WID-1:0] wdata,
    input  logic                read,
    input  logic                write,
    output logic                ready,
    output logic                done,
    output logic [DATA_WID-1:0] valM,
    output logic                dmem_error
);

    localparam int AW = $clog2(MEM_BYTES);
    localparam logic [DATA_WID-1:0] ADDR_MAX = DATA_WID'(MEM_BYTES - 8);

    state_t              state, state_nxt;
    logic [2:0]          cnt;
    logic [AW-1:0]       addr_q;
    mem_req_t            rq;
    logic [DATA_WID-9:0] shreg;

    logic                accept;
    logic                bad;
    logic                noop;
    logic [AW-1:0]       ram_addr;
    logic [7:0]          ram_wdata;
    logic [7:0]          ram_rdata;
    logic                ram_we;

    assign accept = req && (state == IDLE);
    // Full-width compare, so high address bits cannot alias into the RAM.
    assign bad    = (read && write) || (addr > ADDR_MAX);
    assign noop   = !read && !write;

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    // Only the low AW bits are kept: the range check at acceptance already
    // guarantees addr_q + 7 stays inside the RAM.
    assign ram_addr  = addr_q + AW'(cnt);
    assign ram_wdata = rq.wdata[{cnt, 3'b000} +: 8];
    assign ram_we    = (state == XFER) && rq.write && !rst;

    dmem_byte_ram #(.MEM_BYTES(MEM_BYTES)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_addr),
        .wdata (ram_wdata),
        .raddr (ram_addr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (bad || noop) ? DONE : XFER;
            XFER: if (cnt == 3'd7) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 3'd0;
            addr_q     <= '0;
            rq         <= '0;
            shreg      <= '0;
            valM       <= '0;
            dmem_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q   <= addr[AW-1:0];
                        rq.wdata <= wdata;
                        rq.read  <= read;
                        rq.write <= write;
                        cnt      <= 3'd0;
                        if (bad)       dmem_error <= 1'b1;
                        else if (noop) dmem_error <= 1'b0;
                    end
                end
                XFER: begin
                    cnt <= cnt + 3'd1;
                    // Bytes enter at the top and shift down, so after seven
                    // shifts byte 0 sits in the lowest lane.
                    shreg <= {ram_rdata, shreg[DATA_WID-9:8]};
                    if (cnt == 3'd7) begin
                        dmem_error <= 1'b0;
                        if (rq.read) valM <= {ram_rdata, shreg};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed scoreboard bench for dmem_unit: stimulus pushes expected completions,
// a negedge monitor pops and checks them when done pulses.
module tb_dmem_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        read;
    logic        write;
    logic        ready;
    logic        done;
    logic [63:0] valM;
    logic        dmem_error;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    typedef struct {
        int          cyc;
        logic [63:0] val;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    dmem_unit #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .addr       (addr),
        .wdata      (wdata),
        .read       (read),
        .write      (write),
        .ready      (ready),
        .done       (done),
        .valM       (valM),
        .dmem_error (dmem_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL spurious_done: got done=1 expected no completion (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("valM", valM, mon_e.val);
                chk("dmem_error", {63'd0, dmem_error}, {63'd0, mon_e.err});
            end
        end
    end

    // Called at a negedge; returns at the negedge after acceptance (cycle T+1).
    task automatic issue(input logic [63:0] a, input logic [63:0] wd, input logic rd,
                         input logic wr, input logic [63:0] ev, input logic ee,
                         input int lat, input bit expect_done);
        exp_t e;
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            nvec++;
            nmis++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        req = 1'b1; addr = a; wdata = wd; read = rd; write = wr;
        if (expect_done) begin
            e.cyc = cyc + lat;
            e.val = ev;
            e.err = ee;
            sb.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    function automatic logic [7:0] rb(input int i);
        return dut.u_ram.mem[i];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; wdata = '0; read = 1'b0; write = 1'b0;
        for (int i = 0; i < 1024; i++) dut.u_ram.mem[i] = 8'h00;
        // Known word at the top of RAM for the boundary load.
        for (int i = 0; i < 8; i++) begin
            logic [63:0] w;
            w = 64'h1122334455667788;
            dut.u_ram.mem[32'h3F8 + i] = w[8*i +: 8];
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_valM", valM, 64'd0);
        chk("rst_err", {63'd0, dmem_error}, 64'd0);

        // Store then load the same word.
        issue(64'h100, 64'h0123456789ABCDEF, 1'b0, 1'b1, 64'd0, 1'b0, 9, 1'b1);
        wait_idle();
        chk("ram_100", {56'd0, rb(32'h100)}, 64'hEF);
        chk("ram_107", {56'd0, rb(32'h107)}, 64'h01);
        issue(64'h100, 64'h0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b0, 9, 1'b1);
        wait_idle();

        // Boundary and out-of-range accesses.
        issue(64'h3F8, 64'h0, 1'b1, 1'b0, 64'h1122334455667788, 1'b0, 9, 1'b1);
        wait_idle();
        issue(64'h3F9, 64'h0, 1'b1, 1'b0, 64'h1122334455667788, 1'b1, 1, 1'b1);
        wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFF8, 64'hAAAA_AAAA_AAAA_AAAA, 1'b0, 1'b1,
              64'h1122334455667788, 1'b1, 1, 1'b1);
        wait_idle();
        chk("ram_3f8_untouched", {56'd0, rb(32'h3F8)}, 64'h88);

        // Conflicting strobes and no-op.
        issue(64'h10, 64'h5555_5555_5555_5555, 1'b1, 1'b1, 64'h1122334455667788, 1'b1, 1, 1'b1);
        wait_idle();
        chk("ram_10_untouched", {56'd0, rb(32'h10)}, 64'h00);
        issue(64'h20, 64'h0, 1'b0, 1'b0, 64'h1122334455667788, 1'b0, 1, 1'b1);
        wait_idle();

        // Reset during a store: rst high in cycle T+4.
        issue(64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'd0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {63'd0, ready}, 64'd1);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_valM", valM, 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("midrst_ram_%0d", i), {56'd0, rb(32'h200 + i)},
                (i < 3) ? 64'hFF : 64'h00);
        repeat (12) @(negedge clk);

        // Requests while busy are dropped.
        issue(64'h100, 64'h0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 1'b0, 9, 1'b1);
        req = 1'b1; addr = 64'h3F8; wdata = 64'h0; read = 1'b0; write = 1'b1;
        repeat (8) @(negedge clk);
        req = 1'b0;
        wait_idle();
        chk("busy_req_dropped", {56'd0, rb(32'h3F8)}, 64'h88);

        // Back-to-back store and load, completions 10 cycles apart.
        issue(64'h40, 64'hDEADBEEFCAFEF00D, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0, 9, 1'b1);
        issue(64'h40, 64'h0, 1'b1, 1'b0, 64'hDEADBEEFCAFEF00D, 1'b0, 9, 1'b1);
        wait_idle();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
